// File: rtl/alu_seq_top.sv
// alu_seq_top: registered WIDTH-bit ALU with valid/ready on both sides.
// Sum, difference and product finish in one cycle. Quotient and modulo share
// a restoring divider that produces one quotient bit per cycle, MSB first.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready_o high, waiting for valid_i
// CALC  | divider stepping, WIDTH cycles, neither side handshakes
// DONE  | valid_o high, result and flags held until ready_i
module alu_seq_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ctrl_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             err_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    // Divider working registers: quo_q starts as the dividend and is shifted
    // out MSB first while quotient bits are shifted in at the bottom.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mod_q, mod_d;

    logic             accept;
    logic             is_div;
    logic             start_div;
    logic             last_step;
    logic [WIDTH:0]   sum_w;
    logic [PW-1:0]    prod_w;
    logic [WIDTH:0]   shifted_w;
    logic             ge_w;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign ready_o  = (state_q == S_IDLE);
    assign valid_o  = (state_q == S_DONE);
    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign carry_o  = carry_q;
    assign ovf_o    = ovf_q;
    assign err_o    = err_q;

    assign accept    = valid_i && ready_o;
    assign is_div    = (ctrl_i == OP_DIV) || (ctrl_i == OP_MOD);
    assign start_div = accept && is_div && (data1_i != '0);
    assign last_step = (cnt_q == CNT_W'(1));

    assign sum_w  = {1'b0, data0_i} + {1'b0, data1_i};
    assign prod_w = PW'(data0_i) * PW'(data1_i);

    // One restoring step. When the trial subtraction succeeds the true
    // difference is below the divisor, so a WIDTH-bit subtract is exact.
    assign shifted_w = {rem_q, quo_q[WIDTH-1]};
    assign ge_w      = (shifted_w >= {1'b0, div_q});
    assign step_rem  = ge_w ? (shifted_w[WIDTH-1:0] - div_q) : shifted_w[WIDTH-1:0];
    assign step_quo  = {quo_q[WIDTH-2:0], ge_w};

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = start_div ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result, flag and divider next-state computation.
    always_comb begin
        logic [WIDTH-1:0] res_w;
        logic             car_w;
        logic             ovf_w;
        logic             err_w;

        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        mod_d    = mod_q;
        res_w    = '0;
        car_w    = 1'b0;
        ovf_w    = 1'b0;
        err_w    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (ctrl_i)
                        OP_ADD: begin
                            res_w = sum_w[WIDTH-1:0];
                            car_w = sum_w[WIDTH];
                        end
                        OP_SUB: begin
                            res_w = data0_i - data1_i;
                            car_w = (data0_i < data1_i);
                        end
                        OP_MUL: begin
                            res_w = prod_w[WIDTH-1:0];
                            ovf_w = |prod_w[PW-1:WIDTH];
                        end
                        OP_DIV, OP_MOD: begin
                            // Only the divide-by-zero case reaches the result here.
                            res_w = (ctrl_i == OP_DIV) ? '1 : data0_i;
                            err_w = 1'b1;
                        end
                        default: begin
                            err_w = 1'b1;
                        end
                    endcase

                    if (start_div) begin
                        rem_d = '0;
                        quo_d = data0_i;
                        div_d = data1_i;
                        cnt_d = CNT_W'(WIDTH);
                        mod_d = (ctrl_i == OP_MOD);
                    end else begin
                        result_d = res_w;
                        zero_d   = (res_w == '0);
                        carry_d  = car_w;
                        ovf_d    = ovf_w;
                        err_d    = err_w;
                    end
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    res_w    = mod_q ? step_rem : step_quo;
                    result_d = res_w;
                    zero_d   = (res_w == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // Result, flag and divider registers; reset discards any in-flight divide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            mod_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            mod_q    <= mod_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_top.sv
// Directed bench for alu_seq_top at WIDTH=8, plus one WIDTH=16 divide.
module tb_alu_seq_top;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;

    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  ctrl_i = 3'b000;
    logic [7:0]  data0_i = 8'd0;
    logic [7:0]  data1_i = 8'd0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [7:0]  result_o;
    logic        zero_o, carry_o, ovf_o, err_o;

    logic        w_valid_i = 1'b0;
    logic        w_ready_o;
    logic [2:0]  w_ctrl_i = 3'b000;
    logic [15:0] w_data0_i = 16'd0;
    logic [15:0] w_data1_i = 16'd0;
    logic        w_valid_o;
    logic        w_ready_i = 1'b0;
    logic [15:0] w_result_o;
    logic        w_zero_o, w_carry_o, w_ovf_o, w_err_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    alu_seq_top #(.WIDTH(8)) u_dut8 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .ctrl_i  (ctrl_i),
        .data0_i (data0_i),
        .data1_i (data1_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .result_o(result_o),
        .zero_o  (zero_o),
        .carry_o (carry_o),
        .ovf_o   (ovf_o),
        .err_o   (err_o)
    );

    alu_seq_top #(.WIDTH(16)) u_dut16 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (w_valid_i),
        .ready_o (w_ready_o),
        .ctrl_i  (w_ctrl_i),
        .data0_i (w_data0_i),
        .data1_i (w_data1_i),
        .valid_o (w_valid_o),
        .ready_i (w_ready_i),
        .result_o(w_result_o),
        .zero_o  (w_zero_o),
        .carry_o (w_carry_o),
        .ovf_o   (w_ovf_o),
        .err_o   (w_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operation at a negedge; it is accepted on the next posedge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk_i);
        valid_i = 1'b1;
        ctrl_i  = op;
        data0_i = a;
        data1_i = b;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    // Latency counts the accept edge, so a single-cycle op reports 1.
    task automatic wait_valid(output int lat, output logic rdy_bad);
        int cycles = 0;
        rdy_bad = 1'b0;
        while (!valid_o && cycles < 100) begin
            if (ready_o) rdy_bad = 1'b1;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        lat = cycles + 1;
    endtask

    task automatic release_result(input string tag);
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check($sformatf("%s valid_drop", tag), 32'(valid_o), 32'd0);
        check($sformatf("%s ready_rise", tag), 32'(ready_o), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input int exp_lat, input logic [31:0] exp_res,
                          input logic [31:0] exp_zero, input logic [31:0] exp_carry,
                          input logic [31:0] exp_ovf, input logic [31:0] exp_err);
        int   lat;
        logic rdy_bad;
        issue(op, a, b);
        wait_valid(lat, rdy_bad);
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s ready_low_calc", tag), 32'(rdy_bad), 32'd0);
        check($sformatf("%s result", tag), 32'(result_o), exp_res);
        check($sformatf("%s zero", tag), 32'(zero_o), exp_zero);
        check($sformatf("%s carry", tag), 32'(carry_o), exp_carry);
        check($sformatf("%s ovf", tag), 32'(ovf_o), exp_ovf);
        check($sformatf("%s err", tag), 32'(err_o), exp_err);
        release_result(tag);
    endtask

    initial begin
        int   lat;
        logic rdy_bad;
        int   cycles;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst ready", 32'(ready_o), 32'd1);
        check("rst valid", 32'(valid_o), 32'd0);
        check("rst result", 32'(result_o), 32'd0);
        check("rst flags", 32'({zero_o, carry_o, ovf_o, err_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        //      tag          op       A       B      lat  result  z  c  o  e
        run_op("sum",       3'b000, 8'd200, 8'd100, 1, 32'h2C, 0, 1, 0, 0);
        run_op("sub_neg",   3'b001, 8'd5,   8'd7,   1, 32'hFE, 0, 1, 0, 0);
        run_op("sub_zero",  3'b001, 8'd9,   8'd9,   1, 32'h00, 1, 0, 0, 0);
        run_op("mul_ovf",   3'b010, 8'd20,  8'd13,  1, 32'h04, 0, 0, 1, 0);
        run_op("mul_fit",   3'b010, 8'd15,  8'd17,  1, 32'hFF, 0, 0, 0, 0);
        run_op("div",       3'b011, 8'd200, 8'd7,   9, 32'd28, 0, 0, 0, 0);
        run_op("mod",       3'b100, 8'd200, 8'd7,   9, 32'd4,  0, 0, 0, 0);
        run_op("div_small", 3'b011, 8'd5,   8'd9,   9, 32'd0,  1, 0, 0, 0);
        run_op("mod_small", 3'b100, 8'd5,   8'd9,   9, 32'd5,  0, 0, 0, 0);
        run_op("div255",    3'b011, 8'd255, 8'd1,   9, 32'd255, 0, 0, 0, 0);
        run_op("div_by0",   3'b011, 8'h55,  8'd0,   1, 32'hFF, 0, 0, 0, 1);
        run_op("mod_by0",   3'b100, 8'h55,  8'd0,   1, 32'h55, 0, 0, 0, 1);
        run_op("illegal",   3'b110, 8'd12,  8'd3,   1, 32'h00, 1, 0, 0, 1);
        run_op("sum_after", 3'b000, 8'd1,   8'd2,   1, 32'h03, 0, 0, 0, 0);

        // Backpressure: hold DONE, offer a new op that must be ignored.
        issue(3'b000, 8'd200, 8'd100);
        wait_valid(lat, rdy_bad);
        check("bp latency", 32'(lat), 32'd1);
        @(negedge clk_i);
        valid_i = 1'b1;
        ctrl_i  = 3'b010;
        data0_i = 8'd3;
        data1_i = 8'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("bp hold%0d result", i), 32'(result_o), 32'h2C);
            check($sformatf("bp hold%0d carry", i), 32'(carry_o), 32'd1);
            check($sformatf("bp hold%0d valid", i), 32'(valid_o), 32'd1);
            check($sformatf("bp hold%0d ready", i), 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        release_result("bp");
        @(posedge clk_i);
        #1;
        check("bp no_capture valid", 32'(valid_o), 32'd0);
        check("bp no_capture result", 32'(result_o), 32'h2C);

        // Reset in CALC cycle 4 discards the divide.
        issue(3'b011, 8'd200, 8'd7);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_mid pre ready", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check("rst_mid ready", 32'(ready_o), 32'd1);
        check("rst_mid valid", 32'(valid_o), 32'd0);
        check("rst_mid result", 32'(result_o), 32'd0);
        check("rst_mid flags", 32'({zero_o, carry_o, ovf_o, err_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        check("rst_mid discarded", 32'(valid_o), 32'd0);
        run_op("mod_post_rst", 3'b100, 8'd200, 8'd7, 9, 32'd4, 0, 0, 0, 0);

        // WIDTH=16 divide: 255/1 after 17 cycles.
        @(negedge clk_i);
        w_valid_i = 1'b1;
        w_ctrl_i  = 3'b011;
        w_data0_i = 16'd255;
        w_data1_i = 16'd1;
        @(posedge clk_i);
        #1;
        w_valid_i = 1'b0;
        cycles = 0;
        while (!w_valid_o && cycles < 100) begin
            @(posedge clk_i);
            #1;
            cycles++;
        end
        check("w16 latency", 32'(cycles + 1), 32'd17);
        check("w16 result", 32'(w_result_o), 32'd255);
        check("w16 err", 32'(w_err_o), 32'd0);
        @(negedge clk_i);
        w_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        w_ready_i = 1'b0;
        check("w16 release", 32'(w_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_seq_top.md
Name: alu_seq_top

Overview:
- Parametrised, registered successor of the 8-bit five-operation ALU.
- Same operation codes (sum, difference, product, integer quotient, modulo) over WIDTH-bit unsigned operands.
- Adds a valid/ready handshake on both sides, a multi-cycle restoring divider shared by quotient and modulo, and status flags.
- Sits between an operand source (sequencer or register file) and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operands and ctrl_i valid.
- ready_o  output  1  block can accept a new operation.
- ctrl_i  input  3  op code: 000 sum, 001 difference, 010 product, 011 quotient, 100 modulo, 101..111 illegal.
- data0_i  input  WIDTH  operand A (dividend / minuend).
- data1_i  input  WIDTH  operand B (divisor / subtrahend).
- valid_o  output  1  result and flags valid.
- ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  result.
- zero_o  output  1  result_o == 0.
- carry_o  output  1  sum carry-out or difference borrow; 0 for other ops.
- ovf_o  output  1  product upper WIDTH bits nonzero; 0 for other ops.
- err_o  output  1  divide by zero (op 011/100) or illegal op code.

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - FSM goes to IDLE.
  - ready_o=1; valid_o=0; result_o=0; zero_o=0; carry_o=0; ovf_o=0; err_o=0.
  - Divider counter and partial remainder/quotient cleared.
  - In-flight operation discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - Accept occurs when valid_i and ready_o are both high at a rising edge; ctrl_i, data0_i and data1_i are captured.
  - Ops 000/001/010/illegal: result and flags computed and registered on the same edge; next state DONE (latency 1 cycle).
  - Ops 011/100 with data1_i != 0: load divider; next state CALC.
  - Ops 011/100 with data1_i == 0: next state DONE with the divide-by-zero result below (latency 1).
- CALC:
  - ready_o=0, valid_o=0.
  - One restoring-division step per cycle, MSB first, for exactly WIDTH cycles.
  - Counter is ceil(log2(WIDTH+1)) bits.
  - After the final step, next state DONE.
  - Total latency accept->valid_o is WIDTH+1 cycles (9 for WIDTH=8).
- DONE:
  - valid_o=1, ready_o=0.
  - result_o and all flags held stable until ready_i=1 at a rising edge.
  - On that edge, next state IDLE; valid_o drops and ready_o rises in the following cycle.
  - Throughput: at most one operation per 2 cycles for single-cycle ops.
- Arithmetic (all unsigned):
  - Sum: result=(A+B) mod 2^WIDTH; carry_o=bit WIDTH of A+B.
  - Difference: result=(A-B) mod 2^WIDTH; carry_o=1 iff A<B.
  - Product: full 2*WIDTH-bit product; result=lower WIDTH bits; ovf_o=1 iff upper WIDTH bits nonzero.
  - Quotient: result=floor(A/B). Modulo: result=A mod B.
  - Divide by zero: quotient result=all ones; modulo result=A; err_o=1.
  - Illegal op: result=0, err_o=1, zero_o=1.
- Flags are registered with result_o and cleared to 0 when not applicable to the op.
- valid_i while ready_o=0 is ignored; no operand is captured.
- ready_i while valid_o=0 has no effect.

Test Plan:
- Reset, then sum 200+100 (WIDTH=8) -> valid_o 1 cycle after accept; result 44 (0x2C), carry_o=1, zero_o=0.
- Difference 5-7, then 9-9 -> 0xFE with carry_o=1; then 0x00 with zero_o=1, carry_o=0.
- Product 20*13 -> result 0x04, ovf_o=1; then 15*17 -> 0xFF, ovf_o=0.
- Quotient 200/7 -> valid_o exactly 9 cycles after accept, result 28. Modulo 200%7 -> result 4. ready_o=0 throughout CALC.
- Quotient 0x55/0 -> result 0xFF, err_o=1, latency 1. Modulo 0x55/0 -> result 0x55, err_o=1. ctrl_i=110 -> result 0, err_o=1.
- Backpressure and reset:
  - Hold ready_i=0 for 5 cycles in DONE -> result_o/flags stable, new valid_i ignored.
  - Assert rst_i at CALC cycle 4 -> immediate IDLE, all outputs at reset values.
  - Repeat quotient 255/1 at WIDTH=16 -> result 255 after 17 cycles.
